fetch_unit: RTL and testbench

//  - Instruction-fetch front end: owns the program counter and drives the instruction memory word address.
//  - Captures the returned instruction word (combinational read) into a 2-entry fetch buffer.
//  - Presents {instr, instr_pc} to decode with a valid/ready handshake.
//  - Sits between the branch/jump resolution logic (redirect input) and the decode stage.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 89 ++++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//  - XLEN, RESET_VECTOR_DEFAULT, PC_INC, NOP
//  - fetch_state_t : fetch FSM encoding
//  - fetch_entry_t : one fetch-buffer entry {instr, pc}
package riscv_pkg;

    localparam int unsigned XLEN                 = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC               = 32'd4;
    localparam logic [31:0] NOP                  = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer holding {instr, pc} pairs, head at e0_q.
// Entries that are not occupied are kept at zero so the head reads 0 when empty.
// Ports:
//  - clk, rst_n  : clock, async active-low reset
//  - flush       : synchronous clear (wins over push/pop)
//  - push, din   : enqueue din (ignored when full unless popping)
//  - pop         : dequeue head (ignored when empty)
//  - dout        : head entry (registered)
//  - valid       : head entry is valid (registered)
//  - count       : occupancy 0..2 (registered)
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         valid,
    output logic [1:0]   count
);

    fetch_entry_t e0_q;
    fetch_entry_t e1_q;
    logic [1:0]   count_q;
    logic         valid_q;
    logic         full;
    logic         empty;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

    // Storage and occupancy update; the second slot shifts into the head on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else if (flush) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (empty) begin
                        e0_q    <= din;
                        count_q <= 2'd1;
                        valid_q <= 1'b1;
                    end else if (!full) begin
                        e1_q    <= din;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        e0_q    <= e1_q;
                        e1_q    <= '0;
                        count_q <= count_q - 2'd1;
                        valid_q <= full;
                    end
                end
                2'b11: begin
                    if (empty) begin
                        e0_q    <= din;
                        count_q <= 2'd1;
                        valid_q <= 1'b1;
                    end else if (full) begin
                        e0_q <= e1_q;
                        e1_q <= din;
                    end else begin
                        e0_q <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout  = e0_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC selection, boot FSM,
// misaligned-redirect flag and a 2-entry buffer towards decode.
// Ports:
//  - clk, rst             : clock, async active-low reset
//  - imem_addr / imem_rd  : instruction memory address (= pc_q) and read data
//  - redirect_en/_pc      : reload PC and flush the buffer
//  - instr, instr_pc      : head-of-buffer instruction and its PC (0 when invalid)
//  - instr_valid          : head entry valid
//  - dec_ready            : decode accepts the head this cycle
//  - fetch_misal          : one-cycle pulse for a redirect target with pc[1:0] != 0
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rd,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            dec_ready,
    output logic            fetch_misal
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            misal_q;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic            head_valid;
    logic [1:0]      fifo_count;

    assign pop = head_valid & dec_ready;

    // State, PC and misalign registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            misal_q <= redirect_en & (|redirect_pc[1:0]);
        end
    end

    // Next state, push decision and next-PC mux; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN:  push = !redirect_en & ((fifo_count < 2'(FIFO_DEPTH)) | pop);
            default: state_d = BOOT;
        endcase
        if (push) begin
            pc_d = pc_q + PC_INC;
        end
        if (redirect_en) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    assign push_entry.instr = imem_rd;
    assign push_entry.pc    = pc_q;

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (redirect_en),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .valid (head_valid),
        .count (fifo_count)
    );

    assign imem_addr   = pc_q;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_valid = head_valid;
    assign fetch_misal = misal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational imem model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        dec_ready;
    logic        fetch_misal;

    int n_vec;
    int n_fail;

    typedef struct {
        logic        ren;
        logic [31:0] rpc;
        logic        dr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        emisal;
    } vec_t;

    localparam int unsigned NVEC = 19;
    vec_t tbl [NVEC];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .fetch_misal (fetch_misal)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    assign imem_rd = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ren, input logic [31:0] rpc, input logic dr,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] eaddr, input logic emisal);
        vec_t v;
        v.ren = ren; v.rpc = rpc; v.dr = dr;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.emisal = emisal;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [31:0] epc,
                                 input logic [31:0] eaddr, input logic emisal);
        check({tag, ".valid"}, 32'(instr_valid), 32'(ev));
        check({tag, ".instr_pc"}, instr_pc, ev ? epc : 32'h0);
        check({tag, ".instr"}, instr, ev ? mem_word(epc) : 32'h0);
        check({tag, ".imem_addr"}, imem_addr, eaddr);
        check({tag, ".misal"}, 32'(fetch_misal), 32'(emisal));
    endtask

    task automatic apply(input vec_t v, input string tag);
        redirect_en = v.ren;
        redirect_pc = v.rpc;
        dec_ready   = v.dr;
        @(posedge clk);
        #1;
        check_outputs(tag, v.ev, v.epc, v.eaddr, v.emisal);
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        //           ren  rpc           dr   ev   epc           eaddr         misal
        tbl[0]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0); // BOOT -> RUN
        tbl[1]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h4,        1'b0); // first push
        tbl[2]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0); // full
        tbl[3]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0); // stall
        tbl[4]  = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0); // stall
        tbl[5]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'hC,        1'b0); // push+pop full
        tbl[6]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h10,       1'b0);
        tbl[7]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h14,       1'b0);
        tbl[8]  = mk(1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        32'h100,      1'b0); // redirect on full
        tbl[9]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h104,      1'b0);
        tbl[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h108,      1'b0); // push+pop count 1
        tbl[11] = mk(1'b1, 32'h103,      1'b1, 1'b0, 32'h0,        32'h100,      1'b1); // misaligned
        tbl[12] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h104,      1'b0);
        tbl[13] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h108,      1'b0);
        tbl[14] = mk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b0); // wrap
        tbl[15] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,       1'b0);
        tbl[16] = mk(1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4,        1'b0);
        tbl[17] = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0); // refill to 2
        tbl[18] = mk(1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0);

        rst         = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        dec_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset with a full buffer: outputs clear before any edge.
        rst = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_hold", 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;

        // Redirect while in BOOT: target is taken, no push that cycle.
        apply(mk(1'b1, 32'h40, 1'b1, 1'b0, 32'h0,  32'h40, 1'b0), "boot_redir");
        apply(mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'h44, 1'b0), "boot_redir_1");
        apply(mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h44, 32'h48, 1'b0), "boot_redir_2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
